// File: rtl/rd53_cmd_pkg.sv
// RD53A command-stream constants and symbol tables, shared by the command
// encoder and the register-access frame builder.
package rd53_cmd_pkg;

    localparam logic [15:0] SYNC_FRAME = 16'h817E;
    localparam logic [15:0] NOOP_FRAME = 16'h6969;

    localparam logic [15:0] ECR_HDR    = 16'h5A5A;
    localparam logic [15:0] BCR_HDR    = 16'h5959;
    localparam logic [15:0] GPULSE_HDR = 16'h5C5C;
    localparam logic [15:0] CAL_HDR    = 16'h6363;
    localparam logic [15:0] WRREG_HDR  = 16'h6666;
    localparam logic [15:0] RDREG_HDR  = 16'h6565;

    localparam logic [7:0] DATA_SYM [0:31] = '{
        8'h6A, 8'h6C, 8'h71, 8'h72, 8'h74, 8'h8B, 8'h8D, 8'h8E,
        8'h93, 8'h95, 8'h96, 8'h99, 8'h9A, 8'h9C, 8'hA3, 8'hA5,
        8'hA6, 8'hA9, 8'hAA, 8'hAC, 8'hB1, 8'hB2, 8'hB4, 8'hC3,
        8'hC5, 8'hC6, 8'hC9, 8'hCA, 8'hCC, 8'hD1, 8'hD2, 8'hD4
    };

    localparam logic [7:0] TRIG_SYM [1:15] = '{
        8'h2B, 8'h2D, 8'h2E, 8'h33, 8'h35, 8'h36, 8'h39, 8'h3A,
        8'h3C, 8'h4B, 8'h4D, 8'h4E, 8'h53, 8'h55, 8'h56
    };

    // Pattern 0 never reaches here (dropped at capture); it maps to a null symbol.
    function automatic logic [15:0] trig_frame(input logic [3:0] pattern,
                                               input logic [4:0] tag);
        logic [7:0] trig_sym;
        trig_sym = (pattern == 4'd0) ? 8'h00 : TRIG_SYM[pattern];
        return {trig_sym, DATA_SYM[tag]};
    endfunction

endpackage

// File: rtl/rd53_cmd_frame_mux.sv
// Priority select of the next command frame: forced Sync, pending trigger,
// user frame, then idle Sync.
module rd53_cmd_frame_mux
    import rd53_cmd_pkg::*;
(
    input  logic        force_sync,
    input  logic        pending,
    input  logic [3:0]  pend_pattern,
    input  logic [4:0]  pend_tag,
    input  logic        cmd_valid,
    input  logic [15:0] cmd_frame,
    output logic [15:0] frame,
    output logic        is_sync,
    output logic        is_trig
);

    // NOTE: every output gets a default first so no path through the
    // priority chain can leave one unassigned and infer a latch.
    always_comb begin
        frame   = SYNC_FRAME;
        is_sync = 1'b1;
        is_trig = 1'b0;
        if (!force_sync) begin
            if (pending) begin
                frame   = trig_frame(pend_pattern, pend_tag);
                is_sync = 1'b0;
                is_trig = 1'b1;
            end else if (cmd_valid) begin
                frame   = cmd_frame;
                is_sync = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rd53_cmd_tx.sv
// RD53A command encoder: serialises 16-bit frames MSB first, merging user
// frames, a one-entry trigger slot and periodic Sync filler.
module rd53_cmd_tx
    import rd53_cmd_pkg::*;
#(
    parameter int   SYNC_PERIOD = 32,
    parameter logic INVERT      = 1'b0
) (
    input  logic        clk,
    input  logic        rstL,
    input  logic        cmd_valid,
    input  logic [15:0] cmd_frame,
    output logic        cmd_ready,
    input  logic        trig_valid,
    input  logic [3:0]  trig_pattern,
    input  logic [4:0]  trig_tag,
    output logic        trig_ready,
    output logic        serial_o,
    output logic        sync_sent
);

    localparam logic [7:0] SYNC_LAST = 8'(SYNC_PERIOD - 1);

    logic [15:0] sr;
    logic [15:0] next_frame;
    logic [3:0]  bit_cnt;
    logic [7:0]  sync_cnt;
    logic        pending;
    logic [3:0]  pend_pattern;
    logic [4:0]  pend_tag;
    logic        load;
    logic        force_sync;
    logic        sel_sync;
    logic        sel_trig;
    logic        consume;
    logic        capture;

    // bit_cnt resets to 15, so the first cycle after reset is a load cycle.
    assign load       = (bit_cnt == 4'd15);
    assign force_sync = (sync_cnt == SYNC_LAST);

    rd53_cmd_frame_mux u_frame_mux (
        .force_sync   (force_sync),
        .pending      (pending),
        .pend_pattern (pend_pattern),
        .pend_tag     (pend_tag),
        .cmd_valid    (cmd_valid),
        .cmd_frame    (cmd_frame),
        .frame        (next_frame),
        .is_sync      (sel_sync),
        .is_trig      (sel_trig)
    );

    // Handshake strobes are gated by rstL so they read low while reset is held.
    assign consume    = rstL && load && sel_trig;
    assign cmd_ready  = rstL && load && !force_sync && !pending;
    assign trig_ready = rstL && (!pending || consume);
    assign capture    = trig_valid && trig_ready && (trig_pattern != 4'd0);
    assign sync_sent  = rstL && load && sel_sync;
    assign serial_o   = sr[15] ^ INVERT;

    always_ff @(posedge clk) begin
        if (!rstL) begin
            sr           <= '0;
            bit_cnt      <= 4'd15;
            sync_cnt     <= '0;
            pending      <= 1'b0;
            pend_pattern <= '0;
            pend_tag     <= '0;
        end else begin
            if (load) begin
                sr      <= next_frame;
                bit_cnt <= 4'd0;
                if (sel_sync)
                    sync_cnt <= '0;
                else if (sync_cnt != SYNC_LAST)
                    sync_cnt <= sync_cnt + 8'd1;
            end else begin
                sr      <= {sr[14:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
            end

            // A capture in the consume cycle refills the slot with the new request.
            if (capture) begin
                pending      <= 1'b1;
                pend_pattern <= trig_pattern;
                pend_tag     <= trig_tag;
            end else if (consume) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rd53_cmd_tx.sv
// Directed self-checking bench for rd53_cmd_tx: default, SYNC_PERIOD=4 and
// INVERT=1 instances share one stimulus stream.
module tb_rd53_cmd_tx;

    logic        clk;
    logic        rstL;
    logic        cmd_valid;
    logic [15:0] cmd_frame;
    logic        trig_valid;
    logic [3:0]  trig_pattern;
    logic [4:0]  trig_tag;

    logic serial, cmd_ready, trig_ready, sync_sent;
    logic serial4, cmd_ready4, trig_ready4, sync_sent4;
    logic serial_inv, cmd_ready_inv, trig_ready_inv, sync_sent_inv;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] fr, fr4, fr_inv;
    logic        end_rdy, end_rdy4, end_sync, end_sync4, end_trdy;
    int          mid_rdy, mid_sync;
    int          ctl_diff = 0;

    rd53_cmd_tx dut (
        .clk(clk), .rstL(rstL), .cmd_valid(cmd_valid), .cmd_frame(cmd_frame),
        .cmd_ready(cmd_ready), .trig_valid(trig_valid), .trig_pattern(trig_pattern),
        .trig_tag(trig_tag), .trig_ready(trig_ready), .serial_o(serial),
        .sync_sent(sync_sent)
    );

    rd53_cmd_tx #(.SYNC_PERIOD(4)) dut4 (
        .clk(clk), .rstL(rstL), .cmd_valid(cmd_valid), .cmd_frame(cmd_frame),
        .cmd_ready(cmd_ready4), .trig_valid(trig_valid), .trig_pattern(trig_pattern),
        .trig_tag(trig_tag), .trig_ready(trig_ready4), .serial_o(serial4),
        .sync_sent(sync_sent4)
    );

    rd53_cmd_tx #(.INVERT(1'b1)) dut_inv (
        .clk(clk), .rstL(rstL), .cmd_valid(cmd_valid), .cmd_frame(cmd_frame),
        .cmd_ready(cmd_ready_inv), .trig_valid(trig_valid), .trig_pattern(trig_pattern),
        .trig_tag(trig_tag), .trig_ready(trig_ready_inv), .serial_o(serial_inv),
        .sync_sent(sync_sent_inv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Collects one 16-bit frame starting from a load cycle; returns in the next load cycle.
    task automatic get_frame();
        mid_rdy  = 0;
        mid_sync = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0) trig_valid = 1'b0;
            #1;
            fr[15-i]     = serial;
            fr4[15-i]    = serial4;
            fr_inv[15-i] = serial_inv;
            if (cmd_ready_inv !== cmd_ready || sync_sent_inv !== sync_sent ||
                trig_ready_inv !== trig_ready)
                ctl_diff++;
            if (i < 15) begin
                if (cmd_ready === 1'b1 || cmd_ready4 === 1'b1) mid_rdy++;
                if (sync_sent === 1'b1 || sync_sent4 === 1'b1) mid_sync++;
            end
        end
        end_rdy   = cmd_ready;
        end_rdy4  = cmd_ready4;
        end_sync  = sync_sent;
        end_sync4 = sync_sent4;
        end_trdy  = trig_ready;
    endtask

    task automatic test_reset();
        rstL         = 1'b0;
        cmd_valid    = 1'b1;
        cmd_frame    = 16'h6969;
        trig_valid   = 1'b1;
        trig_pattern = 4'h1;
        trig_tag     = 5'd0;
        repeat (3) @(negedge clk);
        #1;
        n_total++;
        if (serial !== 1'b0 || serial4 !== 1'b0) $display("FAIL reset_serial: got %b/%b, expected 0/0", serial, serial4);
        else n_pass++;
        n_total++;
        if (serial_inv !== 1'b1) $display("FAIL reset_serial_inv: got %b, expected 1", serial_inv);
        else n_pass++;
        n_total++;
        if ({cmd_ready, cmd_ready4, trig_ready, trig_ready4, sync_sent, sync_sent4} !== 6'b0)
            $display("FAIL reset_strobes: got %b, expected 000000",
                     {cmd_ready, cmd_ready4, trig_ready, trig_ready4, sync_sent, sync_sent4});
        else n_pass++;
        cmd_valid  = 1'b0;
        trig_valid = 1'b0;
    endtask

    task automatic test_idle();
        @(negedge clk);
        rstL = 1'b1;
        #1;
        n_total++;
        if (sync_sent !== 1'b1 || sync_sent4 !== 1'b1) $display("FAIL idle_first_sync_sent: got %b/%b, expected 1/1", sync_sent, sync_sent4);
        else n_pass++;
        n_total++;
        if (cmd_ready !== 1'b1) $display("FAIL idle_ready_without_valid: got %b, expected 1", cmd_ready);
        else n_pass++;
        for (int k = 0; k < 2; k++) begin
            get_frame();
            n_total++;
            if (fr !== 16'h817E || fr4 !== 16'h817E) $display("FAIL idle_frame%0d: got %h/%h, expected 817e", k, fr, fr4);
            else n_pass++;
            n_total++;
            if (fr_inv !== 16'h7E81) $display("FAIL idle_frame_inv%0d: got %h, expected 7e81", k, fr_inv);
            else n_pass++;
            n_total++;
            if (end_sync !== 1'b1 || mid_sync !== 0) $display("FAIL idle_sync_pulse%0d: got end=%b mid=%0d, expected end=1 mid=0", k, end_sync, mid_sync);
            else n_pass++;
        end
    endtask

    task automatic test_sync_period();
        logic [15:0] exp4 [0:8];
        int          mid_total;
        logic        exp_rdy;
        mid_total = 0;
        for (int k = 0; k < 9; k++) exp4[k] = ((k % 4) == 3) ? 16'h817E : 16'h6969;
        cmd_valid = 1'b1;
        cmd_frame = 16'h6969;
        #1;
        n_total++;
        if (cmd_ready4 !== 1'b1) $display("FAIL sp4_first_ready: got %b, expected 1", cmd_ready4);
        else n_pass++;
        for (int k = 0; k < 8; k++) begin
            get_frame();
            mid_total += mid_rdy;
            exp_rdy = (exp4[k+1] == 16'h6969);
            n_total++;
            if (fr4 !== exp4[k]) $display("FAIL sp4_frame%0d: got %h, expected %h", k, fr4, exp4[k]);
            else n_pass++;
            n_total++;
            if (end_rdy4 !== exp_rdy || end_sync4 !== !exp_rdy)
                $display("FAIL sp4_load%0d: got ready=%b sync=%b, expected ready=%b sync=%b",
                         k, end_rdy4, end_sync4, exp_rdy, !exp_rdy);
            else n_pass++;
            n_total++;
            if (fr !== 16'h6969 || fr_inv !== 16'h9696) $display("FAIL sp32_frame%0d: got %h/%h, expected 6969/9696", k, fr, fr_inv);
            else n_pass++;
        end
        n_total++;
        if (mid_total !== 0) $display("FAIL sp4_ready_mid_slot: got %0d, expected 0", mid_total);
        else n_pass++;
    endtask

    task automatic test_trigger();
        trig_valid   = 1'b1;
        trig_pattern = 4'h1;
        trig_tag     = 5'd0;
        #1;
        n_total++;
        if (trig_ready !== 1'b1 || cmd_ready !== 1'b1) $display("FAIL trig_accept: got trig_ready=%b cmd_ready=%b, expected 1/1", trig_ready, cmd_ready);
        else n_pass++;
        get_frame();
        n_total++;
        if (fr !== 16'h6969) $display("FAIL trig_prev_user: got %h, expected 6969", fr);
        else n_pass++;
        n_total++;
        if (end_rdy !== 1'b0) $display("FAIL trig_load_ready: got %b, expected 0", end_rdy);
        else n_pass++;
        get_frame();
        n_total++;
        if (fr !== 16'h2B6A) $display("FAIL trig_frame: got %h, expected 2b6a", fr);
        else n_pass++;
        n_total++;
        if (end_rdy !== 1'b1) $display("FAIL trig_after_ready: got %b, expected 1", end_rdy);
        else n_pass++;
        get_frame();
        n_total++;
        if (fr !== 16'h6969) $display("FAIL trig_user_after: got %h, expected 6969", fr);
        else n_pass++;
        cmd_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int held_hi;
        held_hi = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 3) begin
                trig_valid   = 1'b1;
                trig_pattern = 4'h2;
                trig_tag     = 5'd1;
            end else if (i == 4) begin
                trig_pattern = 4'h3;
                trig_tag     = 5'd2;
            end
            #1;
            if (i == 3) begin
                n_total++;
                if (trig_ready !== 1'b1) $display("FAIL b2b_first_ready: got %b, expected 1", trig_ready);
                else n_pass++;
            end else if (i == 4) begin
                n_total++;
                if (trig_ready !== 1'b0) $display("FAIL b2b_second_held: got %b, expected 0", trig_ready);
                else n_pass++;
            end else if (i > 4 && i < 16) begin
                if (trig_ready !== 1'b0) held_hi++;
            end else if (i == 16) begin
                n_total++;
                if (trig_ready !== 1'b1) $display("FAIL b2b_consume_ready: got %b, expected 1", trig_ready);
                else n_pass++;
            end
        end
        n_total++;
        if (held_hi !== 0) $display("FAIL b2b_hold: got %0d ready cycles, expected 0", held_hi);
        else n_pass++;
        get_frame();
        n_total++;
        if (fr !== 16'h2D6C) $display("FAIL b2b_frame_a: got %h, expected 2d6c", fr);
        else n_pass++;
        get_frame();
        n_total++;
        if (fr !== 16'h2E71) $display("FAIL b2b_frame_b: got %h, expected 2e71", fr);
        else n_pass++;
        get_frame();
        n_total++;
        if (fr !== 16'h817E) $display("FAIL b2b_then_idle: got %h, expected 817e", fr);
        else n_pass++;
    endtask

    task automatic test_pattern_zero();
        trig_valid   = 1'b1;
        trig_pattern = 4'h0;
        trig_tag     = 5'd3;
        get_frame();
        n_total++;
        if (fr !== 16'h817E) $display("FAIL pz_frame0: got %h, expected 817e", fr);
        else n_pass++;
        n_total++;
        if (end_trdy !== 1'b1) $display("FAIL pz_not_pending: got %b, expected 1", end_trdy);
        else n_pass++;
        get_frame();
        n_total++;
        if (fr !== 16'h817E) $display("FAIL pz_frame1: got %h, expected 817e", fr);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        logic [6:0] part;
        cmd_valid = 1'b1;
        cmd_frame = 16'hA5C3;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (i == 1) cmd_valid = 1'b0;
            if (i == 2) begin
                trig_valid   = 1'b1;
                trig_pattern = 4'h5;
                trig_tag     = 5'd7;
            end
            if (i == 3) trig_valid = 1'b0;
            #1;
            part[7-i] = serial;
            if (i == 2) begin
                n_total++;
                if (trig_ready !== 1'b1) $display("FAIL mr_trig_ready: got %b, expected 1", trig_ready);
                else n_pass++;
            end
        end
        n_total++;
        if (part !== 7'h52) $display("FAIL mr_prefix: got %h, expected 52", part);
        else n_pass++;
        @(negedge clk);
        rstL = 1'b0;
        @(negedge clk);
        #1;
        n_total++;
        if (serial !== 1'b0 || serial_inv !== 1'b1) $display("FAIL mr_stop: got %b/%b, expected 0/1", serial, serial_inv);
        else n_pass++;
        repeat (2) @(negedge clk);
        @(negedge clk);
        rstL = 1'b1;
        #1;
        n_total++;
        if (sync_sent !== 1'b1 || trig_ready !== 1'b1) $display("FAIL mr_release: got sync_sent=%b trig_ready=%b, expected 1/1", sync_sent, trig_ready);
        else n_pass++;
        get_frame();
        n_total++;
        if (fr !== 16'h817E) $display("FAIL mr_first_frame: got %h, expected 817e", fr);
        else n_pass++;
        get_frame();
        n_total++;
        if (fr !== 16'h817E) $display("FAIL mr_pending_cleared: got %h, expected 817e", fr);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_sync_period();
        test_trigger();
        test_back_to_back();
        test_pattern_zero();
        test_mid_reset();
        n_total++;
        if (ctl_diff !== 0) $display("FAIL invert_ctl_equal: got %0d differing cycles, expected 0", ctl_diff);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
